// File: rtl/ofs_fim_axis_pkt_gen_if.sv
// AXI-S stream interface used between the packet generator and its downstream pipeline.
// Width parameters travel with the interface so that endpoints derive their bus sizes from it.
interface pcie_ss_axis_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0] tuser_vendor;

    modport source (output tvalid, tlast, tdata, tkeep, tuser_vendor, input tready);
    modport sink   (input tvalid, tlast, tdata, tkeep, tuser_vendor, output tready);
endinterface

// File: rtl/ofs_fim_axis_pkt_gen.sv
// AXI-S packet transmitter: emits num_pkts framed packets of pkt_len bytes with an
// incrementing byte pattern seeded by the packet index, honouring tready backpressure.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// SEND  | presenting beats; advances on tvalid & tready
// DONE  | one cycle after the final tlast handshake; done pulses, busy still high
module ofs_fim_axis_pkt_gen #(
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [CNT_W-1:0] num_pkts,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkts_sent,
    pcie_ss_axis_if.source   axis_m
);

    localparam int DATA_W   = $bits(axis_m.tdata);
    localparam int BPB      = DATA_W / 8;
    localparam int LOG2_BPB = $clog2(BPB);
    localparam int BEAT_W   = LEN_W - LOG2_BPB + 1;
    localparam logic [7:0] BPB_B = 8'(BPB);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t              state_q, state_nx;
    logic [CNT_W-1:0]    num_q, num_nx;
    logic [CNT_W-1:0]    cnt_q, cnt_nx, cnt_inc;
    logic [BEAT_W-1:0]   beats_m1_q, beats_m1_nx;
    logic [BEAT_W-1:0]   beats_left_q, beats_left_nx;
    logic [BPB-1:0]      keep_last_q, keep_last_nx;
    logic                stop_q, stop_nx;
    logic                valid_q, valid_nx;
    logic                last_q, last_nx;
    logic [DATA_W-1:0]   data_q, data_nx;
    logic [BPB-1:0]      keep_q, keep_nx;
    logic                done_q, done_nx;
    logic [7:0]          base_nx;

    logic                cfg_ok;
    logic [BEAT_W-1:0]   nb_in;
    logic [LOG2_BPB-1:0] rem_in;
    logic [BPB-1:0]      keep_in;

    function automatic logic [DATA_W-1:0] fill(input logic [7:0] base);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < BPB; k++) d[k*8 +: 8] = base + 8'(k);
        return d;
    endfunction

    assign cfg_ok  = (pkt_len != '0) && (num_pkts != '0);
    assign rem_in  = pkt_len[LOG2_BPB-1:0];
    assign nb_in   = {1'b0, pkt_len[LEN_W-1:LOG2_BPB]} + BEAT_W'(rem_in != '0);
    assign keep_in = (rem_in == '0) ? '1 : ~({BPB{1'b1}} << rem_in);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_nx      = state_q;
        num_nx        = num_q;
        cnt_nx        = cnt_q;
        beats_m1_nx   = beats_m1_q;
        beats_left_nx = beats_left_q;
        keep_last_nx  = keep_last_q;
        stop_nx       = stop_q;
        valid_nx      = valid_q;
        last_nx       = last_q;
        data_nx       = data_q;
        keep_nx       = keep_q;
        done_nx       = 1'b0;
        base_nx       = data_q[7:0];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_nx = '0;
                    if (cfg_ok) begin
                        state_nx      = SEND;
                        num_nx        = num_pkts;
                        beats_m1_nx   = nb_in - BEAT_W'(1);
                        beats_left_nx = nb_in - BEAT_W'(1);
                        keep_last_nx  = keep_in;
                        stop_nx       = 1'b0;
                        valid_nx      = 1'b1;
                        data_nx       = fill(8'h00);
                        last_nx       = (nb_in == BEAT_W'(1));
                        keep_nx       = last_nx ? keep_in : '1;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            SEND: begin
                if (stop) stop_nx = 1'b1;
                if (valid_q && axis_m.tready) begin
                    if (last_q) begin
                        cnt_nx = cnt_inc;
                        // stop is checked live too, so a stop on the final beat ends the run here
                        if ((cnt_inc == num_q) || stop_q || stop) begin
                            state_nx = DONE;
                            valid_nx = 1'b0;
                            last_nx  = 1'b0;
                            data_nx  = '0;
                            keep_nx  = '0;
                            done_nx  = 1'b1;
                        end else begin
                            base_nx       = 8'(cnt_inc);
                            beats_left_nx = beats_m1_q;
                            data_nx       = fill(base_nx);
                            last_nx       = (beats_m1_q == '0);
                            keep_nx       = last_nx ? keep_last_q : '1;
                        end
                    end else begin
                        base_nx       = data_q[7:0] + BPB_B;
                        beats_left_nx = beats_left_q - BEAT_W'(1);
                        data_nx       = fill(base_nx);
                        last_nx       = (beats_left_q == BEAT_W'(1));
                        keep_nx       = last_nx ? keep_last_q : '1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                stop_nx  = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            num_q        <= '0;
            cnt_q        <= '0;
            beats_m1_q   <= '0;
            beats_left_q <= '0;
            keep_last_q  <= '0;
            stop_q       <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_nx;
            num_q        <= num_nx;
            cnt_q        <= cnt_nx;
            beats_m1_q   <= beats_m1_nx;
            beats_left_q <= beats_left_nx;
            keep_last_q  <= keep_last_nx;
            stop_q       <= stop_nx;
            valid_q      <= valid_nx;
            last_q       <= last_nx;
            data_q       <= data_nx;
            keep_q       <= keep_nx;
            done_q       <= done_nx;
        end
    end

    assign axis_m.tvalid       = valid_q;
    assign axis_m.tlast        = last_q;
    assign axis_m.tdata        = data_q;
    assign axis_m.tkeep        = keep_q;
    assign axis_m.tuser_vendor = '0;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pkts_sent = cnt_q;

endmodule

// File: tb/tb_ofs_fim_axis_pkt_gen.sv
// Directed bench for ofs_fim_axis_pkt_gen at DATA_W=512 (64 bytes per beat).
// Each test task drives one scenario and checks the captured beats inline.
module tb_ofs_fim_axis_pkt_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] pkt_len;
    logic [15:0] num_pkts;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;

    int n_cmp = 0;
    int n_err = 0;

    pcie_ss_axis_if #(.DATA_W(512), .USER_W(10)) axis_if ();

    ofs_fim_axis_pkt_gen #(.LEN_W(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .pkt_len   (pkt_len),
        .num_pkts  (num_pkts),
        .busy      (busy),
        .done      (done),
        .pkts_sent (pkts_sent),
        .axis_m    (axis_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    // captured handshakes and run statistics from collect()
    logic [511:0] bq[$];
    logic [63:0]  kq[$];
    logic         lq[$];
    int done_cnt, stall_bad, bubbles, done_gap, first_valid, valid_after_done;
    logic busy_at_done, timed_out;

    function automatic logic [511:0] exp_data(input int p, input int b);
        logic [511:0] d;
        for (int k = 0; k < 64; k++) d[k*8 +: 8] = 8'((p + b * 64 + k) % 256);
        return d;
    endfunction

    task automatic start_run(input logic [15:0] len, input logic [15:0] n);
        @(negedge clk);
        pkt_len  = len;
        num_pkts = n;
        start    = 1'b1;
    endtask

    // Runs the stream until done plus three cycles, recording handshakes. No checking here.
    task automatic collect(input int ready_mode, input int stop_pkt, input int stop_beat,
                           input int restart_at);
        int pkt, beat, after_done, last_hs;
        logic prev_stall, prev_l;
        logic [511:0] prev_d;
        logic [63:0] prev_k;
        bq.delete(); kq.delete(); lq.delete();
        done_cnt = 0; stall_bad = 0; bubbles = 0; done_gap = -1; first_valid = -1;
        valid_after_done = 0; busy_at_done = 1'b0; timed_out = 1'b0;
        pkt = 0; beat = 0; after_done = -1; last_hs = -1; prev_stall = 1'b0;
        prev_d = '0; prev_k = '0; prev_l = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                pkt_len  = 16'd64;
                num_pkts = 16'd1;
            end
            stop = axis_if.tvalid && (pkt == stop_pkt) && (beat == stop_beat);
            axis_if.tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (prev_stall && axis_if.tvalid &&
                (axis_if.tdata != prev_d || axis_if.tkeep != prev_k || axis_if.tlast != prev_l))
                stall_bad++;
            if (first_valid < 0 && axis_if.tvalid) first_valid = cyc;
            if (after_done >= 0 && axis_if.tvalid) valid_after_done++;
            if (done) begin
                done_cnt++;
                if (after_done < 0) begin
                    after_done   = 0;
                    done_gap     = cyc - last_hs;
                    busy_at_done = busy;
                end
            end
            if (after_done < 0 && first_valid >= 0 && !axis_if.tvalid) bubbles++;
            if (axis_if.tvalid && axis_if.tready) begin
                bq.push_back(axis_if.tdata);
                kq.push_back(axis_if.tkeep);
                lq.push_back(axis_if.tlast);
                last_hs = cyc;
                if (axis_if.tlast) begin
                    pkt++;
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            prev_stall = axis_if.tvalid && !axis_if.tready;
            prev_d = axis_if.tdata;
            prev_k = axis_if.tkeep;
            prev_l = axis_if.tlast;
            if (after_done >= 0) begin
                after_done++;
                if (after_done > 3) break;
            end
        end
        if (after_done < 0) timed_out = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        axis_if.tready = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++; if (axis_if.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b need 0", axis_if.tvalid); end
        n_cmp++; if (axis_if.tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b need 0", axis_if.tlast); end
        n_cmp++; if (axis_if.tdata !== 512'd0) begin n_err++; $display("FAIL reset_tdata got %h need 0", axis_if.tdata); end
        n_cmp++; if (axis_if.tkeep !== 64'd0) begin n_err++; $display("FAIL reset_tkeep got %h need 0", axis_if.tkeep); end
        n_cmp++; if (axis_if.tuser_vendor !== 10'd0) begin n_err++; $display("FAIL reset_tuser got %h need 0", axis_if.tuser_vendor); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done got %b need 00", {busy, done}); end
        n_cmp++; if (pkts_sent !== 16'd0) begin n_err++; $display("FAIL reset_pkts_sent got %0d need 0", pkts_sent); end
    endtask

    task automatic test_single();
        start_run(16'd64, 16'd1);
        collect(0, -1, -1, -1);
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL single_timeout got timeout need done"); end
        n_cmp++; if (first_valid !== 0) begin n_err++; $display("FAIL single_latency got %0d need 0", first_valid); end
        n_cmp++; if (bq.size() !== 1) begin n_err++; $display("FAIL single_beats got %0d need 1", bq.size()); end
        if (bq.size() >= 1) begin
            n_cmp++; if (bq[0] !== exp_data(0, 0)) begin n_err++; $display("FAIL single_tdata got %h need %h", bq[0], exp_data(0, 0)); end
            n_cmp++; if (kq[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL single_tkeep got %h need all ones", kq[0]); end
            n_cmp++; if (lq[0] !== 1'b1) begin n_err++; $display("FAIL single_tlast got %b need 1", lq[0]); end
        end
        n_cmp++; if (done_gap !== 1) begin n_err++; $display("FAIL single_done_gap got %0d need 1", done_gap); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL single_done_count got %0d need 1", done_cnt); end
        n_cmp++; if (busy_at_done !== 1'b1) begin n_err++; $display("FAIL single_busy_at_done got %b need 1", busy_at_done); end
        n_cmp++; if (pkts_sent !== 16'd1) begin n_err++; $display("FAIL single_pkts_sent got %0d need 1", pkts_sent); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after got %b need 0", busy); end
    endtask

    task automatic test_back_to_back();
        start_run(16'd100, 16'd2);
        collect(0, -1, -1, -1);
        n_cmp++; if (bq.size() !== 4) begin n_err++; $display("FAIL b2b_beats got %0d need 4", bq.size()); end
        n_cmp++; if (bubbles !== 0) begin n_err++; $display("FAIL b2b_bubbles got %0d need 0", bubbles); end
        if (bq.size() == 4) begin
            n_cmp++; if ({lq[0], lq[1], lq[2], lq[3]} !== 4'b0101) begin n_err++; $display("FAIL b2b_tlast got %b need 0101", {lq[0], lq[1], lq[2], lq[3]}); end
            n_cmp++; if (kq[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL b2b_keep0 got %h need all ones", kq[0]); end
            n_cmp++; if (kq[1] !== 64'h0000_000F_FFFF_FFFF) begin n_err++; $display("FAIL b2b_keep1 got %h need 0000000fffffffff", kq[1]); end
            n_cmp++; if (kq[3] !== 64'h0000_000F_FFFF_FFFF) begin n_err++; $display("FAIL b2b_keep3 got %h need 0000000fffffffff", kq[3]); end
            n_cmp++; if (bq[2][7:0] !== 8'h01) begin n_err++; $display("FAIL b2b_p1b0_byte0 got %h need 01", bq[2][7:0]); end
            n_cmp++; if (bq[1][7:0] !== 8'h40) begin n_err++; $display("FAIL b2b_p0b1_byte0 got %h need 40", bq[1][7:0]); end
            n_cmp++; if (bq[3] !== exp_data(1, 1)) begin n_err++; $display("FAIL b2b_p1b1_tdata got %h need %h", bq[3], exp_data(1, 1)); end
        end
        n_cmp++; if (pkts_sent !== 16'd2) begin n_err++; $display("FAIL b2b_pkts_sent got %0d need 2", pkts_sent); end
    endtask

    task automatic test_backpressure();
        int bad;
        start_run(16'd200, 16'd3);
        collect(1, -1, -1, -1);
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL bp_timeout got timeout need done"); end
        n_cmp++; if (bq.size() !== 12) begin n_err++; $display("FAIL bp_handshakes got %0d need 12", bq.size()); end
        n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL bp_stall_stable got %0d changes need 0", stall_bad); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL bp_done_count got %0d need 1", done_cnt); end
        n_cmp++; if (pkts_sent !== 16'd3) begin n_err++; $display("FAIL bp_pkts_sent got %0d need 3", pkts_sent); end
        if (bq.size() == 12) begin
            bad = 0;
            for (int i = 0; i < 12; i++) begin
                if (bq[i] !== exp_data(i / 4, i % 4)) bad++;
                if (lq[i] !== ((i % 4) == 3)) bad++;
                if (kq[i] !== (((i % 4) == 3) ? 64'h0000_0000_0000_00FF : 64'hFFFF_FFFF_FFFF_FFFF)) bad++;
            end
            n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_beat_contents got %0d bad fields need 0", bad); end
            n_cmp++; if (bq[9][7:0] !== 8'h42) begin n_err++; $display("FAIL bp_p2b1_byte0 got %h need 42", bq[9][7:0]); end
        end
    endtask

    task automatic test_stop();
        start_run(16'd1000, 16'd10);
        collect(0, 2, 5, -1);
        n_cmp++; if (bq.size() !== 48) begin n_err++; $display("FAIL stop_beats got %0d need 48", bq.size()); end
        if (bq.size() == 48) begin
            n_cmp++; if (lq[47] !== 1'b1) begin n_err++; $display("FAIL stop_last_tlast got %b need 1", lq[47]); end
            n_cmp++; if (kq[47] !== 64'h0000_00FF_FFFF_FFFF) begin n_err++; $display("FAIL stop_last_keep got %h need 000000ffffffffff", kq[47]); end
            n_cmp++; if (bq[37][7:0] !== 8'h42) begin n_err++; $display("FAIL stop_p2b5_byte0 got %h need 42", bq[37][7:0]); end
        end
        n_cmp++; if (pkts_sent !== 16'd3) begin n_err++; $display("FAIL stop_pkts_sent got %0d need 3", pkts_sent); end
        n_cmp++; if (valid_after_done !== 0) begin n_err++; $display("FAIL stop_valid_after got %0d need 0", valid_after_done); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL stop_done_count got %0d need 1", done_cnt); end
    endtask

    task automatic test_zero_cfg();
        start_run(16'd0, 16'd5);
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({done, busy, axis_if.tvalid} !== 3'b100) begin n_err++; $display("FAIL zero_len_done_busy_valid got %b need 100", {done, busy, axis_if.tvalid}); end
        @(negedge clk);
        n_cmp++; if ({done, busy, axis_if.tvalid} !== 3'b000) begin n_err++; $display("FAIL zero_len_after got %b need 000", {done, busy, axis_if.tvalid}); end
        start_run(16'd64, 16'd0);
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({done, busy, axis_if.tvalid} !== 3'b100) begin n_err++; $display("FAIL zero_num_done_busy_valid got %b need 100", {done, busy, axis_if.tvalid}); end
        // restart with different config while running must be ignored
        start_run(16'd128, 16'd2);
        collect(0, -1, -1, 1);
        n_cmp++; if (bq.size() !== 4) begin n_err++; $display("FAIL restart_beats got %0d need 4", bq.size()); end
        n_cmp++; if (pkts_sent !== 16'd2) begin n_err++; $display("FAIL restart_pkts_sent got %0d need 2", pkts_sent); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL restart_done_count got %0d need 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        start_run(16'd1000, 16'd1);
        axis_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        n_cmp++; if (axis_if.tvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid got %b need 1", axis_if.tvalid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({axis_if.tvalid, axis_if.tlast, busy} !== 3'b000) begin n_err++; $display("FAIL rstmid_async got %b need 000", {axis_if.tvalid, axis_if.tlast, busy}); end
        n_cmp++; if (axis_if.tdata !== 512'd0) begin n_err++; $display("FAIL rstmid_tdata got %h need 0", axis_if.tdata); end
        n_cmp++; if (pkts_sent !== 16'd0) begin n_err++; $display("FAIL rstmid_pkts_sent got %0d need 0", pkts_sent); end
        @(negedge clk);
        rst_n = 1'b1;
        start_run(16'd64, 16'd1);
        collect(0, -1, -1, -1);
        n_cmp++; if (bq.size() !== 1) begin n_err++; $display("FAIL rstmid_beats got %0d need 1", bq.size()); end
        if (bq.size() == 1) begin
            n_cmp++; if (bq[0] !== exp_data(0, 0)) begin n_err++; $display("FAIL rstmid_tdata_clean got %h need %h", bq[0], exp_data(0, 0)); end
        end
        n_cmp++; if (pkts_sent !== 16'd1) begin n_err++; $display("FAIL rstmid_pkts_after got %0d need 1", pkts_sent); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        pkt_len = '0;
        num_pkts = '0;
        axis_if.tready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_single();
        test_back_to_back();
        test_backpressure();
        test_stop();
        test_zero_cfg();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
